// File: rtl/spi_primary_pkg.sv
// spi_primary_pkg: shared state encoding and transaction geometry for the SPI primary.
package spi_primary_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  localparam int NBITS = 16;
  localparam int RW_BIT = 15;
  localparam int RX_BITS = 8;
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: registered one-cycle tick every HALF_CYCLES cycles while enabled.
module spi_half_tick #(
  parameter int HALF_CYCLES = 2
) (
  input  logic spi_clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = HALF_CYCLES > 1 ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_CYCLES - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge spi_clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      tick <= 1'b0;
    end else if (clr || !en) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= cnt == LAST;
      cnt <= cnt == LAST ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/spi_primary.sv
// spi_primary: mode-3 SPI primary, one 16-clock register read/write per start handshake.
// Define SPI_BUSY_EN to add a busy output covering SETUP, SHIFT and HOLD.
module spi_primary
  import spi_primary_pkg::*;
#(
  parameter int HALF_CYCLES = 2
) (
  input  logic                  spi_clk,
  input  logic                  reset,
  input  logic [NBITS-1:0]      data_tx,
  input  logic                  start,
  output logic                  done,
  output logic [RX_BITS-1:0]    data_rx,
  output logic                  SPI_SDI,
  input  logic                  SPI_SDO,
  output logic                  SPI_CLK,
  output logic                  SPI_CSN
`ifdef SPI_BUSY_EN
  ,
  output logic                  busy
`endif
);
  state_t state;
  logic [NBITS-1:0] sh;
  logic [RX_BITS-1:0] rx;
  logic [3:0] bit_cnt;
  logic rw;
  logic tick;
  spi_half_tick #(.HALF_CYCLES(HALF_CYCLES)) u_tick (
    .spi_clk(spi_clk),
    .reset(reset),
    .en(state inside {SETUP, SHIFT, HOLD}),
    .clr(state == IDLE),
    .tick(tick)
  );
  always_ff @(posedge spi_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sh <= '0;
      rx <= '0;
      bit_cnt <= '0;
      rw <= 1'b0;
      SPI_CSN <= 1'b1;
      SPI_CLK <= 1'b1;
      SPI_SDI <= 1'b0;
      done <= 1'b0;
      data_rx <= '0;
`ifdef SPI_BUSY_EN
      busy <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (start) begin
          // a read only sends its command byte; the data half goes out as zeros
          sh <= data_tx[RW_BIT] ? {data_tx[NBITS-1:RX_BITS], RX_BITS'(0)} : data_tx;
          rw <= data_tx[RW_BIT];
          bit_cnt <= '0;
          SPI_CSN <= 1'b0;
          SPI_SDI <= data_tx[RW_BIT];
          state <= SETUP;
`ifdef SPI_BUSY_EN
          busy <= 1'b1;
`endif
        end
        SETUP: begin
          SPI_SDI <= sh[NBITS-1];
          if (tick) begin
            SPI_CLK <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: if (tick) begin
          if (!SPI_CLK) begin
            SPI_CLK <= 1'b1;
            rx <= {rx[RX_BITS-2:0], SPI_SDO};
          end else if (bit_cnt == 4'(NBITS - 1))
            state <= HOLD;
          else begin
            SPI_CLK <= 1'b0;
            bit_cnt <= bit_cnt + 4'd1;
            sh <= sh << 1;
            SPI_SDI <= sh[NBITS-2];
          end
        end
        HOLD: if (tick) begin
          SPI_CSN <= 1'b1;
          SPI_SDI <= 1'b0;
          done <= 1'b1;
          data_rx <= rw ? rx : data_rx;
          state <= DONE;
`ifdef SPI_BUSY_EN
          busy <= 1'b0;
`endif
        end
        DONE: if (!start) begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_spi_primary.sv
// tb_spi_primary: directed bench with a cycle-indexed pin model and mode-3 peripheral models.
module tb_spi_primary;
  localparam int HC0 = 2;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] data_tx0 = '0, data_tx1 = '0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic done0, done1, sdi0, sdi1, sclk0, sclk1, csn0, csn1;
  logic sdo0 = 1'b0, sdo1 = 1'b0;
  logic [7:0] data_rx0, data_rx1;
`ifdef SPI_BUSY_EN
  logic busy0, busy1;
`endif
  spi_primary #(.HALF_CYCLES(HC0)) u_dut (
    .spi_clk(clk), .reset(reset), .data_tx(data_tx0), .start(start0), .done(done0),
    .data_rx(data_rx0), .SPI_SDI(sdi0), .SPI_SDO(sdo0), .SPI_CLK(sclk0), .SPI_CSN(csn0)
`ifdef SPI_BUSY_EN
    , .busy(busy0)
`endif
  );
  spi_primary #(.HALF_CYCLES(1)) u_dut1 (
    .spi_clk(clk), .reset(reset), .data_tx(data_tx1), .start(start1), .done(done1),
    .data_rx(data_rx1), .SPI_SDI(sdi1), .SPI_SDO(sdo1), .SPI_CLK(sclk1), .SPI_CSN(csn1)
`ifdef SPI_BUSY_EN
    , .busy(busy1)
`endif
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // peripheral 0: shifts in SDI on SCLK rise, drives response on SCLK fall
  logic [15:0] resp0 = '0, prx0 = '0;
  int fcnt0 = 0, rcnt0 = 0;
  always @(negedge csn0) begin fcnt0 = 0; rcnt0 = 0; prx0 = '0; end
  always @(negedge sclk0) if (!csn0 && fcnt0 < 16) begin sdo0 = resp0[15-fcnt0]; fcnt0++; end
  always @(posedge sclk0) if (!csn0) begin prx0 = {prx0[14:0], sdi0}; rcnt0++; end

  // peripheral 1: receive only, plus SCLK period measurement
  int cyc = 0, nf1 = 0, fa1 = 0, fb1 = 0, rcnt1 = 0;
  logic [15:0] prx1 = '0;
  always @(posedge clk) cyc++;
  always @(negedge csn1) begin nf1 = 0; rcnt1 = 0; prx1 = '0; end
  always @(negedge sclk1) if (!csn1) begin
    if (nf1 == 0) fa1 = cyc;
    if (nf1 == 1) fb1 = cyc;
    nf1++;
  end
  always @(posedge sclk1) if (!csn1) begin prx1 = {prx1[14:0], sdi1}; rcnt1++; end

  // pin model: k = clock edges since the start edge
  int k = -1;
  logic trk = 1'b0;
  logic [15:0] htx = '0;
  always @(negedge clk) if (trk) begin
    int t;
    logic e_done, e_clk, e_sdi;
    k++;
    t = k - HC0 - 1;
    e_done = k >= 34*HC0 + 1;
    e_clk = !(k > HC0 && t < 32*HC0 && (t % (2*HC0)) < HC0);
    if (k <= HC0) e_sdi = htx[15];
    else if (t < 32*HC0) e_sdi = htx[15 - t/(2*HC0)];
    else e_sdi = 1'b0;
    chk("csn", {15'd0, csn0}, {15'd0, e_done});
    chk("sclk", {15'd0, sclk0}, {15'd0, e_clk});
    chk("done", {15'd0, done0}, {15'd0, e_done});
    if (k < 33*HC0 + 1 || e_done) chk("sdi", {15'd0, sdi0}, {15'd0, e_sdi});
`ifdef SPI_BUSY_EN
    chk("busy", {15'd0, busy0}, {15'd0, !e_done});
`endif
  end

  task automatic txn0(input logic [15:0] tx, input logic [7:0] r, input logic [7:0] exp_rx, input int hold);
    int n;
    @(negedge clk);
    chk("csn_gap", {15'd0, csn0}, 16'd1);
    data_tx0 = tx;
    resp0 = {8'h00, r};
    start0 = 1'b1;
    @(posedge clk);
    htx = tx[15] ? {tx[15:8], 8'h00} : tx;
    k = -1;
    trk = 1'b1;
    #1 data_tx0 = ~tx;
    n = -1;
    do begin @(negedge clk); n++; end while (!done0 && n < 200);
    chk("latency", 16'(n), 16'd69);
    chk("data_rx", {8'd0, data_rx0}, {8'd0, exp_rx});
    chk("peri_word", prx0, htx);
    chk("sclk_rises", 16'(rcnt0), 16'd16);
    repeat (hold) @(negedge clk);
    chk("single_txn", 16'(rcnt0), 16'd16);
    trk = 1'b0;
    start0 = 1'b0;
    @(posedge clk);
    #1 chk("done_fall", {15'd0, done0}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #1 reset = 1'b1;
    #2;
    chk("rst_csn", {15'd0, csn0}, 16'd1);
    chk("rst_sclk", {15'd0, sclk0}, 16'd1);
    chk("rst_sdi", {15'd0, sdi0}, 16'd0);
    chk("rst_done", {15'd0, done0}, 16'd0);
    chk("rst_rx", {8'd0, data_rx0}, 16'd0);
    @(negedge clk) reset = 1'b0;
    txn0(16'h2D08, 8'h00, 8'h00, 0);
    chk("write_word", prx0, 16'h2D08);
    txn0(16'h80A7, 8'hE5, 8'hE5, 200);
    chk("read_sdi_zero", prx0, 16'h8000);
    txn0(16'h3108, 8'h5A, 8'hE5, 0);
    txn0(16'hB13C, 8'h08, 8'h08, 0);
    txn0(16'h80FF, 8'hE5, 8'hE5, 0);
    // abort a write during bit 5
    @(negedge clk);
    data_tx0 = 16'h2D08;
    resp0 = '0;
    start0 = 1'b1;
    @(posedge clk);
    htx = 16'h2D08;
    k = -1;
    trk = 1'b1;
    repeat (25) @(negedge clk);
    trk = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort_csn", {15'd0, csn0}, 16'd1);
    chk("abort_sclk", {15'd0, sclk0}, 16'd1);
    chk("abort_done", {15'd0, done0}, 16'd0);
    chk("abort_rx", {8'd0, data_rx0}, 16'd0);
    start0 = 1'b0;
    @(negedge clk) reset = 1'b0;
    txn0(16'h2D08, 8'h00, 8'h00, 0);
    // HALF_CYCLES=1 instance
    @(negedge clk);
    data_tx1 = 16'h2D08;
    start1 = 1'b1;
    @(posedge clk);
    n = -1;
    do begin @(negedge clk); n++; end while (!done1 && n < 200);
    chk("latency_h1", 16'(n), 16'd35);
    chk("word_h1", prx1, 16'h2D08);
    chk("rises_h1", 16'(rcnt1), 16'd16);
    chk("period_h1", 16'(fb1 - fa1), 16'd2);
    chk("csn_h1", {15'd0, csn1}, 16'd1);
    start1 = 1'b0;
    @(posedge clk);
    #1 chk("done_fall_h1", {15'd0, done1}, 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
